// File: rtl/hue_sched_pkg.sv
// Shared types and constants for the hue stage scheduler.
package hue_sched_pkg;

  localparam int DATA_W = 16;
  localparam int FUNC_W = 2;

  // Function select 0 is not a real hue operation; such requests are consumed and dropped.
  localparam logic [1:0] FUNC_INVALID = 2'd0;

  // In-flight transaction tag: which requester issued it.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/hue_tag_pipe.sv
// LATENCY-deep tag delay line. Loaded in the cycle a transaction sits on the
// datapath input, so the head stage lines up with the cycle its result is due.
module hue_tag_pipe
  import hue_sched_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  tag_t tag_in,
  output tag_t head,
  output logic any_vld
);

  tag_t [LATENCY-1:0] stage;

  // Shift every cycle; reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  // Any stage still carrying a live tag keeps the scheduler busy.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_vld = any_vld | stage[i].valid;
  end

  assign head = stage[LATENCY-1];

endmodule

// File: rtl/hue_stage_sched.sv
// Two-requester round-robin front end for a shared fixed-latency hue stage.
// Grants one request per cycle, tags it, and steers the returning result back.
module hue_stage_sched #(
  parameter int DATA_W  = hue_sched_pkg::DATA_W,
  parameter int FUNC_W  = hue_sched_pkg::FUNC_W,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic [FUNC_W-1:0] i_req0_function,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic [FUNC_W-1:0] i_req1_function,
  output logic              o_req1_ready,
  output logic [DATA_W-1:0] o_dp_data,
  output logic [FUNC_W-1:0] o_dp_function,
  output logic              o_dp_valid,
  input  logic [DATA_W-1:0] i_dp_data,
  input  logic              i_dp_valid,
  output logic [DATA_W-1:0] o_res0_data,
  output logic              o_res0_valid,
  output logic [DATA_W-1:0] o_res1_data,
  output logic              o_res1_valid,
  output logic              o_busy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_drop_cnt
);
  import hue_sched_pkg::*;

  logic              gnt0, gnt1, gnt_any;
  logic              rr_ptr;   // requester that wins the next conflict
  logic              dp_id;    // issuer of the transaction on o_dp_*
  logic [DATA_W-1:0] sel_data;
  logic [FUNC_W-1:0] sel_func;
  logic              sel_drop;
  tag_t              tag_in, head;
  logic              tag_any;

  // Round-robin grant; a lone requester always wins, conflicts go to rr_ptr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_enable) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign gnt_any      = gnt0 | gnt1;
  assign sel_data     = gnt1 ? i_req1_data : i_req0_data;
  assign sel_func     = gnt1 ? i_req1_function : i_req0_function;
  assign sel_drop     = (sel_func == FUNC_W'(FUNC_INVALID));

  // Issue registers, arbitration pointer and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dp_valid    <= 1'b0;
      o_dp_data     <= '0;
      o_dp_function <= '0;
      dp_id         <= 1'b0;
      rr_ptr        <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      o_dp_valid <= gnt_any && !sel_drop;
      if (gnt_any && !sel_drop) begin
        o_dp_data     <= sel_data;
        o_dp_function <= sel_func;
        dp_id         <= gnt1;
      end
      // A dropped request still used its slot, so the pointer moves too.
      if (gnt_any) rr_ptr <= gnt0;
      if (gnt_any && sel_drop && (o_drop_cnt != {CNT_W{1'b1}}))
        o_drop_cnt <= o_drop_cnt + CNT_W'(1);
    end
  end

  assign tag_in = '{valid: o_dp_valid, id: dp_id};

  hue_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .tag_in  (tag_in),
    .head    (head),
    .any_vld (tag_any)
  );

  // Return router: steer a matched result to its issuer, flag any mismatch.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_res0_data  <= '0;
      o_res0_valid <= 1'b0;
      o_res1_data  <= '0;
      o_res1_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_res0_valid <= i_dp_valid && head.valid && !head.id;
      o_res1_valid <= i_dp_valid && head.valid && head.id;
      if (i_dp_valid && head.valid) begin
        if (head.id) o_res1_data <= i_dp_data;
        else         o_res0_data <= i_dp_data;
      end
      if (i_dp_valid != head.valid) o_err <= 1'b1;
    end
  end

  assign o_busy = o_dp_valid | tag_any | o_res0_valid | o_res1_valid;

endmodule

// File: tb/tb_hue_stage_sched.sv
// Bench for hue_stage_sched: vector table for arbitration/issue, scoreboard
// for returning results, hand-written sequences for saturation and errors.
module tb_hue_stage_sched;

  logic        i_clk, i_rstn, i_enable;
  logic        i_req0_valid, i_req1_valid;
  logic [15:0] i_req0_data, i_req1_data;
  logic [1:0]  i_req0_function, i_req1_function;
  logic        o_req0_ready, o_req1_ready;
  logic [15:0] o_dp_data;
  logic [1:0]  o_dp_function;
  logic        o_dp_valid;
  logic [15:0] i_dp_data;
  logic        i_dp_valid;
  logic [15:0] o_res0_data, o_res1_data;
  logic        o_res0_valid, o_res1_valid;
  logic        o_busy, o_err;
  logic [7:0]  o_drop_cnt;

  hue_stage_sched #(.DATA_W(16), .FUNC_W(2), .LATENCY(2), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable),
    .i_req0_valid(i_req0_valid), .i_req0_data(i_req0_data),
    .i_req0_function(i_req0_function), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_data(i_req1_data),
    .i_req1_function(i_req1_function), .o_req1_ready(o_req1_ready),
    .o_dp_data(o_dp_data), .o_dp_function(o_dp_function), .o_dp_valid(o_dp_valid),
    .i_dp_data(i_dp_data), .i_dp_valid(i_dp_valid),
    .o_res0_data(o_res0_data), .o_res0_valid(o_res0_valid),
    .o_res1_data(o_res1_data), .o_res1_valid(o_res1_valid),
    .o_busy(o_busy), .o_err(o_err), .o_drop_cnt(o_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: result = data ^ 0x0080, two cycles after o_dp_valid,
  // or three when 'late' is set.
  logic        late = 1'b0;
  logic [2:0]  pv = '0;
  logic [15:0] pd [3];
  always @(posedge i_clk) begin
    pv    <= {pv[1:0], o_dp_valid};
    pd[0] <= o_dp_data ^ 16'h0080;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign i_dp_valid = late ? pv[2] : pv[1];
  assign i_dp_data  = late ? pd[2] : pd[1];

  // Scoreboard of expected results.
  typedef struct {
    logic        id;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  logic mon_en = 1'b1;

  always @(posedge i_clk) begin
    #1;
    if (mon_en && (o_res0_valid || o_res1_valid)) begin
      if (o_res0_valid && o_res1_valid) begin
        chk("res_both_valid", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        chk("res_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_port", {31'd0, o_res1_valid}, {31'd0, e.id});
        chk("res_data", {16'd0, (o_res1_valid ? o_res1_data : o_res0_data)}, {16'd0, e.data});
        chk("res_cycle", cyc, e.cyc);
      end
    end
  end

  typedef struct {
    logic        en;
    logic        v0;
    logic [15:0] d0;
    logic [1:0]  f0;
    logic        v1;
    logic [15:0] d1;
    logic [1:0]  f1;
    logic        r0;
    logic        r1;
  } vec_t;
  vec_t tbl[16];

  task automatic row(input int i, input logic en, input logic v0, input logic [15:0] d0,
                     input logic [1:0] f0, input logic v1, input logic [15:0] d1,
                     input logic [1:0] f1, input logic r0, input logic r1);
    tbl[i] = '{en, v0, d0, f0, v1, d1, f1, r0, r1};
  endtask

  task automatic drive(input logic v0, input logic [15:0] d0, input logic [1:0] f0,
                       input logic v1, input logic [15:0] d1, input logic [1:0] f1);
    i_req0_valid = v0; i_req0_data = d0; i_req0_function = f0;
    i_req1_valid = v1; i_req1_data = d1; i_req1_function = f1;
  endtask

  function automatic logic [31:0] all_outs_or();
    return {31'd0, |{o_req0_ready, o_req1_ready, o_dp_data, o_dp_function, o_dp_valid,
                     o_res0_data, o_res0_valid, o_res1_data, o_res1_valid,
                     o_busy, o_err, o_drop_cnt}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic seen;
    //               en    v0    d0        f0    v1    d1        f1    r0    r1
    row( 0, 1'b1, 1'b1, 16'h0101, 2'd1, 1'b1, 16'h0201, 2'd1, 1'b1, 1'b0);
    row( 1, 1'b1, 1'b1, 16'h0102, 2'd1, 1'b1, 16'h0201, 2'd1, 1'b0, 1'b1);
    row( 2, 1'b1, 1'b1, 16'h0102, 2'd1, 1'b1, 16'h0202, 2'd1, 1'b1, 1'b0);
    row( 3, 1'b1, 1'b1, 16'h0103, 2'd1, 1'b1, 16'h0202, 2'd1, 1'b0, 1'b1);
    row( 4, 1'b1, 1'b1, 16'h0103, 2'd1, 1'b1, 16'h0203, 2'd1, 1'b1, 1'b0);
    row( 5, 1'b1, 1'b1, 16'h0104, 2'd1, 1'b1, 16'h0203, 2'd1, 1'b0, 1'b1);
    row( 6, 1'b1, 1'b1, 16'h0025, 2'd2, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    row( 7, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'hFFC7, 2'd3, 1'b0, 1'b1);
    row( 8, 1'b0, 1'b1, 16'h0111, 2'd1, 1'b1, 16'h0222, 2'd1, 1'b0, 1'b0);
    row( 9, 1'b1, 1'b1, 16'h0111, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    row(10, 1'b0, 1'b1, 16'h0301, 2'd1, 1'b1, 16'h0401, 2'd1, 1'b0, 1'b0);
    row(11, 1'b1, 1'b1, 16'h0301, 2'd1, 1'b1, 16'h0401, 2'd1, 1'b0, 1'b1);
    row(12, 1'b1, 1'b1, 16'h0301, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    row(13, 1'b1, 1'b1, 16'h1234, 2'd0, 1'b1, 16'h0055, 2'd2, 1'b0, 1'b1);
    row(14, 1'b1, 1'b1, 16'h1234, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    row(15, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);

    // Reset state.
    i_rstn = 1'b0; i_enable = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0);
    #12;
    chk("reset_outputs", all_outs_or(), 32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    tick();

    // Vector table: arbitration, issue, drop, enable gating.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic iss;
      v = tbl[i];
      i_enable = v.en;
      drive(v.v0, v.d0, v.f0, v.v1, v.d1, v.f1);
      #1;
      chk($sformatf("ready0[%0d]", i), {31'd0, o_req0_ready}, {31'd0, v.r0});
      chk($sformatf("ready1[%0d]", i), {31'd0, o_req1_ready}, {31'd0, v.r1});
      iss = (v.r0 && v.f0 != 2'd0) || (v.r1 && v.f1 != 2'd0);
      if (iss)
        sb.push_back('{v.r1, (v.r1 ? v.d1 : v.d0) ^ 16'h0080, cyc + 4});
      tick();
      chk($sformatf("dp_valid[%0d]", i), {31'd0, o_dp_valid}, {31'd0, iss});
      if (iss) begin
        chk($sformatf("dp_data[%0d]", i), {16'd0, o_dp_data}, {16'd0, v.r1 ? v.d1 : v.d0});
        chk($sformatf("dp_func[%0d]", i), {30'd0, o_dp_function}, {30'd0, v.r1 ? v.f1 : v.f0});
      end
    end
    i_enable = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("sb_drain", sb.size(), 32'd0);
    tick();
    chk("err_clean", {31'd0, o_err}, 32'd0);
    chk("busy_idle", {31'd0, o_busy}, 32'd0);
    chk("drop_cnt_1", {24'd0, o_drop_cnt}, 32'd1);

    // 300 function-0 requests: nothing issued, counter saturates.
    seen = 1'b0;
    drive(1'b1, 16'h0BAD, 2'd0, 1'b0, 16'h0, 2'd0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (o_dp_valid) seen = 1'b1;
      if (i == 253) chk("drop_cnt_fe", {24'd0, o_drop_cnt}, 32'hFE);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0);
    tick();
    chk("func0_no_issue", {31'd0, seen}, 32'd0);
    chk("drop_cnt_sat", {24'd0, o_drop_cnt}, 32'hFF);

    // Late datapath return: error is flagged and sticks until reset.
    mon_en = 1'b0;
    late = 1'b1;
    seen = 1'b0;
    drive(1'b1, 16'h0033, 2'd1, 1'b0, 16'h0, 2'd0);
    tick();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_res0_valid || o_res1_valid) seen = 1'b1;
    end
    chk("late_err", {31'd0, o_err}, 32'd1);
    chk("late_no_result", {31'd0, seen}, 32'd0);
    late = 1'b0;
    repeat (4) tick();
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    i_rstn = 1'b0;
    #2;
    chk("err_cleared_by_reset", {31'd0, o_err}, 32'd0);
    tick();
    i_rstn = 1'b1;
    tick();

    // Reset with two transactions in flight.
    drive(1'b1, 16'h0011, 2'd1, 1'b0, 16'h0, 2'd0);
    tick();
    drive(1'b0, 16'h0, 2'd0, 1'b1, 16'h0022, 2'd1);
    tick();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0);
    i_rstn = 1'b0;
    #1;
    chk("midflight_reset_outputs", all_outs_or(), 32'd0);
    #2 i_rstn = 1'b1;
    repeat (4) tick();
    chk("orphan_result_err", {31'd0, o_err}, 32'd1);
    i_rstn = 1'b0;
    #2 i_rstn = 1'b1;
    repeat (2) tick();
    chk("final_err_clear", {31'd0, o_err}, 32'd0);
    chk("final_idle", {31'd0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
